// File: rtl/rrv64_clkgate_ctrl.sv
// ---------------------------------------------------------------------------
// rrv64_clkgate_ctrl
// Idle-detect / wake-up sequencer for one L1D clock-gate cell. It counts a
// quiet window before it drops the gate enable. On new demand it turns the
// clock back on, then waits a settle window before it accepts requesters.
//
// Ports
//   clk_i          free-running clock
//   rst_i          asynchronous active-high reset
//   req_valid_i    per-requester demand, held until ready
//   req_ready_o    per-requester accept (domain clock running)
//   busy_i         gated domain has outstanding work
//   force_on_i     CSR/debug override, keeps the clock enabled
//   scan_en_i      DFT test enable
//   clk_enable_o   gate cell enable (registered)
//   clk_senable_o  gate cell test enable (passthrough of scan_en_i)
//   gated_o        status: domain clock off (registered)
//   gate_events_o  saturating count of ON->OFF transitions
// ---------------------------------------------------------------------------
module rrv64_clkgate_ctrl #(
    parameter int N_REQ    = 4,
    parameter int IDLE_CYC = 16,
    parameter int WAKE_CYC = 2,
    parameter int EVT_W    = 16,
    parameter int CNT_W    = $clog2(((IDLE_CYC > WAKE_CYC) ? IDLE_CYC : WAKE_CYC) + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [N_REQ-1:0] req_valid_i,
    output logic [N_REQ-1:0] req_ready_o,
    input  logic             busy_i,
    input  logic             force_on_i,
    input  logic             scan_en_i,
    output logic             clk_enable_o,
    output logic             clk_senable_o,
    output logic             gated_o,
    output logic [EVT_W-1:0] gate_events_o
);

    typedef enum logic [1:0] {
        ST_ON        = 2'd0,
        ST_IDLE_WAIT = 2'd1,
        ST_OFF       = 2'd2,
        ST_WAKE      = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(IDLE_CYC - 1);
    // Only reached when WAKE_CYC > 0; the clamp keeps the constant legal otherwise.
    localparam logic [CNT_W-1:0] WAKE_LAST = CNT_W'((WAKE_CYC > 0) ? WAKE_CYC - 1 : 0);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             evt_inc;
    logic             activity;
    logic             clk_en_q;
    logic             gated_q;
    logic [EVT_W-1:0] gate_events_q;

    function automatic logic [EVT_W-1:0] sat_inc(input logic [EVT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    assign activity = (|req_valid_i) | busy_i | force_on_i;

    // Ready is gated by reset as well, so nothing is accepted while the
    // domain is being reset even though the state already reads ON.
    assign req_ready_o   = (!rst_i && (state == ST_ON || state == ST_IDLE_WAIT)) ?
                           req_valid_i : '0;
    assign clk_senable_o = scan_en_i;
    assign clk_enable_o  = clk_en_q;
    assign gated_o       = gated_q;
    assign gate_events_o = gate_events_q;

    // Next-state / counter decode
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        evt_inc   = 1'b0;
        case (state)
            ST_ON: begin
                cnt_nxt = '0;
                if (!activity) begin
                    if (IDLE_CYC == 1) begin
                        state_nxt = ST_OFF;
                        evt_inc   = 1'b1;
                    end else begin
                        state_nxt = ST_IDLE_WAIT;
                        cnt_nxt   = CNT_ONE;
                    end
                end
            end
            ST_IDLE_WAIT: begin
                // Activity on the last quiet cycle still wins over gating.
                if (activity) begin
                    state_nxt = ST_ON;
                    cnt_nxt   = '0;
                end else if (cnt == IDLE_LAST) begin
                    state_nxt = ST_OFF;
                    cnt_nxt   = '0;
                    evt_inc   = 1'b1;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            ST_OFF: begin
                cnt_nxt = '0;
                if (activity) begin
                    state_nxt = (WAKE_CYC == 0) ? ST_ON : ST_WAKE;
                end
            end
            ST_WAKE: begin
                // Demand is ignored here; the settle window always completes.
                if (cnt == WAKE_LAST) begin
                    state_nxt = ST_ON;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: begin
                state_nxt = ST_ON;
                cnt_nxt   = '0;
            end
        endcase
    end

    // State register; outputs registered from next state so they track state exactly
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state         <= ST_ON;
            cnt           <= '0;
            clk_en_q      <= 1'b1;
            gated_q       <= 1'b0;
            gate_events_q <= '0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            clk_en_q <= (state_nxt != ST_OFF);
            gated_q  <= (state_nxt == ST_OFF);
            if (evt_inc) begin
                gate_events_q <= sat_inc(gate_events_q);
            end
        end
    end

endmodule

// File: tb/tb_rrv64_clkgate_ctrl.sv
module tb_rrv64_clkgate_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [3:0]  req_valid = '0;
    logic [3:0]  req_ready;
    logic        busy = 1'b0;
    logic        force_on = 1'b0;
    logic        scan_en = 1'b0;
    logic        clk_en;
    logic        clk_sen;
    logic        gated;
    logic [15:0] evts;

    // Second instance: fastest gate/wake loop with a narrow event counter.
    logic [3:0]  req_valid2 = '0;
    logic [3:0]  req_ready2;
    logic        busy2 = 1'b1;
    logic        force2 = 1'b0;
    logic        scan2 = 1'b0;
    logic        clk_en2;
    logic        clk_sen2;
    logic        gated2;
    logic [7:0]  evts2;

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    rrv64_clkgate_ctrl #(.N_REQ(4), .IDLE_CYC(16), .WAKE_CYC(2)) u_dut (
        .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid), .req_ready_o(req_ready),
        .busy_i(busy), .force_on_i(force_on), .scan_en_i(scan_en),
        .clk_enable_o(clk_en), .clk_senable_o(clk_sen), .gated_o(gated),
        .gate_events_o(evts)
    );

    rrv64_clkgate_ctrl #(.N_REQ(4), .IDLE_CYC(1), .WAKE_CYC(0), .EVT_W(8)) u_sat (
        .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid2), .req_ready_o(req_ready2),
        .busy_i(busy2), .force_on_i(force2), .scan_en_i(scan2),
        .clk_enable_o(clk_en2), .clk_senable_o(clk_sen2), .gated_o(gated2),
        .gate_events_o(evts2)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Quiet from here: enable must hold for 16 edges' worth of cycles, then drop.
    task automatic idle_to_gate(input string tag, input int exp_evt);
        int drops = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (clk_en !== 1'b1) drops++;
        end
        check_eq({tag, "_early_drop"}, drops, 0);
        tick();
        check_eq({tag, "_clk_en"}, clk_en, 0);
        check_eq({tag, "_gated"}, gated, 1);
        check_eq({tag, "_events"}, evts, exp_evt);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        // Test 1: reset values, then gating after the quiet window
        #3 rst = 1'b1;
        req_valid = 4'b1111;
        #20;
        check_eq("rst_clk_en", clk_en, 1);
        check_eq("rst_gated", gated, 0);
        check_eq("rst_ready", req_ready, 0);
        check_eq("rst_events", evts, 0);
        req_valid = 4'b0000;
        tick();
        rst = 1'b0;
        idle_to_gate("t1", 1);

        // Test 2: wake on requester 2
        req_valid = 4'b0100;
        tick();
        check_eq("t2_clk_en_t1", clk_en, 1);
        check_eq("t2_gated_t1", gated, 0);
        check_eq("t2_ready_t1", req_ready, 4'b0000);
        tick();
        check_eq("t2_ready_t2", req_ready, 4'b0000);
        tick();
        check_eq("t2_ready_t3", req_ready, 4'b0100);
        req_valid = 4'b0000;

        // Test 3: activity on the final quiet cycle cancels gating
        for (int i = 0; i < 15; i++) tick();
        busy = 1'b1;
        req_valid = 4'b1001;
        #1;
        check_eq("t3_ready_last_quiet", req_ready, 4'b1001);
        tick();
        check_eq("t3_clk_en", clk_en, 1);
        check_eq("t3_events", evts, 1);
        busy = 1'b0;
        req_valid = 4'b0000;
        idle_to_gate("t3_restart", 2);

        // Test 4: force_on wakes from OFF and blocks gating
        force_on = 1'b1;
        begin
            int drops = 0;
            for (int i = 0; i < 100; i++) begin
                tick();
                if (clk_en !== 1'b1) drops++;
            end
            check_eq("t4_force_drops", drops, 0);
        end
        check_eq("t4_events", evts, 2);
        force_on = 1'b0;
        idle_to_gate("t4_release", 3);

        // Test 5: reset mid-WAKE and mid-OFF
        req_valid = 4'b0001;
        tick();
        check_eq("t5_wake_clk_en", clk_en, 1);
        #2 rst = 1'b1;
        #1;
        check_eq("t5_wake_rst_ready", req_ready, 4'b0000);
        check_eq("t5_wake_rst_events", evts, 0);
        check_eq("t5_wake_rst_clk_en", clk_en, 1);
        req_valid = 4'b0000;
        #1 rst = 1'b0;
        idle_to_gate("t5_after_wake", 1);
        #2 rst = 1'b1;
        #1;
        check_eq("t5_off_rst_clk_en", clk_en, 1);
        check_eq("t5_off_rst_gated", gated, 0);
        check_eq("t5_off_rst_events", evts, 0);
        #1 rst = 1'b0;
        idle_to_gate("t5_after_off", 1);

        // Test 6: event counter saturation, scan passthrough every cycle
        begin
            int sen_bad = 0;
            for (int i = 1; i <= 300; i++) begin
                busy2 = 1'b0;
                scan_en = ~scan_en;
                scan2 = ~scan2;
                #1;
                if (clk_sen !== scan_en || clk_sen2 !== scan2) sen_bad++;
                tick();
                if (i == 1) begin
                    check_eq("t6_fast_gate", clk_en2, 0);
                    check_eq("t6_fast_gated", gated2, 1);
                end
                busy2 = 1'b1;
                scan_en = ~scan_en;
                scan2 = ~scan2;
                #1;
                if (clk_sen !== scan_en || clk_sen2 !== scan2) sen_bad++;
                tick();
                if (i == 1) check_eq("t6_fast_wake", clk_en2, 1);
                if (i == 10) check_eq("t6_events_10", evts2, 10);
                if (i == 255) check_eq("t6_events_255", evts2, 255);
            end
            check_eq("t6_events_sat", evts2, 255);
            check_eq("t6_scan_mirror", sen_bad, 0);
        end
        check_eq("t6_main_gated", gated, 1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
